mult_share_ctrl: RTL and testbench

//  Sequencer and 2-way arbiter for the shared shift-add multiplier datapath
//  (shift register + accumulator). Accepts multiply jobs from two requesters,

---
 rtl/mult_pkg.sv | 16 +
 rtl/rr_arb2.sv | 55 +++++
 rtl/mult_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mult_share_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: FSM states and
// shift-register select encodings.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        BIT     = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    localparam logic [1:0] SR_HOLD  = 2'd0;
    localparam logic [1:0] SR_LOAD  = 2'd1;
    localparam logic [1:0] SR_SHIFT = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational; the priority pointer
// only advances when a grant is actually taken (enable && grant).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // Pointer register: 0 favours requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant selection: the favoured requester wins, otherwise the other one.
    always_comb begin
        grant = 2'b00;
        if (ptr_q == 1'b0) begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end else begin
                grant = 2'b00;
            end
        end else begin
            if (req[1]) begin
                grant = 2'b10;
            end else if (req[0]) begin
                grant = 2'b01;
            end else begin
                grant = 2'b00;
            end
        end
    end

    // Pointer update: after a grant, favour the requester that just lost.
    always_comb begin
        ptr_d = ptr_q;
        if (enable && (grant != 2'b00)) begin
            ptr_d = grant[0];
        end else begin
            ptr_d = ptr_q;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Sequencer and 2-way round-robin arbiter for a shared shift-add multiplier
// datapath; drives the datapath controls and returns the product to the owner.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic           req1,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           ack0,
    output logic           ack1,
    output logic           done0,
    output logic           done1,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic [N-1:0]   dp_a,
    input  logic [2*N-1:0] acc_q,
    output logic           acc_ld,
    output logic           acc_clr,
    output logic [1:0]     srsel
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           owner_q, owner_d;
    logic [2*N-1:0] product_q, product_d;
    logic [1:0]     done_q, done_d;

    logic [1:0]     grant;
    logic           arb_en;

    // Arbitration is only live in IDLE and never while reset is asserted.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .enable (arb_en),
        .grant  (grant)
    );

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            owner_q   <= 1'b0;
            product_q <= '0;
            done_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            owner_q   <= owner_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        owner_d   = owner_q;
        product_d = product_q;
        done_d    = 2'b00;
        case (state_q)
            IDLE: begin
                if (arb_en && (grant != 2'b00)) begin
                    a_d     = grant[1] ? a1 : a0;
                    b_d     = grant[1] ? b1 : b0;
                    owner_d = grant[1];
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                k_d     = '0;
                state_d = BIT;
            end
            BIT: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = CAPTURE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = BIT;
                end
            end
            CAPTURE: begin
                product_d = acc_q;
                done_d    = owner_q ? 2'b10 : 2'b01;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Datapath control and acknowledge outputs, decoded from the current state.
    always_comb begin
        ack0    = 1'b0;
        ack1    = 1'b0;
        acc_ld  = 1'b0;
        acc_clr = 1'b0;
        srsel   = SR_HOLD;
        case (state_q)
            IDLE: begin
                ack0 = arb_en & grant[0];
                ack1 = arb_en & grant[1];
            end
            LOAD: begin
                acc_clr = 1'b1;
                srsel   = SR_LOAD;
            end
            BIT: begin
                acc_ld = b_q[k_q];
                // The last bit step adds without shifting.
                if (k_q == K_LAST) begin
                    srsel = SR_HOLD;
                end else begin
                    srsel = SR_SHIFT;
                end
            end
            CAPTURE: begin
                srsel = SR_HOLD;
            end
            default: begin
                srsel = SR_HOLD;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign dp_a    = a_q;
    assign product = product_q;
    assign done0   = done_q[0];
    assign done1   = done_q[1];

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed self-checking bench for mult_share_ctrl with a behavioural
// shift-add datapath (shift register + accumulator) closing the loop.
module tb_mult_share_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1, done0, done1, busy;
    logic [7:0] product;
    logic [3:0] dp_a;
    logic [7:0] acc_q;
    logic       acc_ld, acc_clr;
    logic [1:0] srsel;

    logic [7:0] sr_m;
    logic [7:0] acc_m;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    mult_share_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .ack0    (ack0),
        .ack1    (ack1),
        .done0   (done0),
        .done1   (done1),
        .product (product),
        .busy    (busy),
        .dp_a    (dp_a),
        .acc_q   (acc_q),
        .acc_ld  (acc_ld),
        .acc_clr (acc_clr),
        .srsel   (srsel)
    );

    // Behavioural datapath driven by the controller outputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_m  <= 8'd0;
            acc_m <= 8'd0;
        end else begin
            case (srsel)
                2'd1:    sr_m <= {4'd0, dp_a};
                2'd2:    sr_m <= sr_m << 1;
                default: sr_m <= sr_m;
            endcase
            if (acc_clr) acc_m <= 8'd0;
            else if (acc_ld) acc_m <= acc_m + sr_m;
        end
    end

    assign acc_q = acc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the ack cycle; ends in the done cycle. Inputs nr0/nr1/na/nb are
    // applied right after the ack edge, so they must not affect the running job.
    task automatic run_job(input logic who, input logic [3:0] aa, input logic [3:0] bb,
                           input logic [7:0] exp_p, input logic nr0, input logic nr1,
                           input logic [3:0] na, input logic [3:0] nb);
        step();
        req0 = nr0;
        req1 = nr1;
        if (who) begin
            a1 = na; b1 = nb;
        end else begin
            a0 = na; b0 = nb;
        end
        #1;
        chk("load_busy", busy, 1);
        chk("load_clr", acc_clr, 1);
        chk("load_srsel", srsel, 1);
        chk("load_ld", acc_ld, 0);
        chk("load_dpa", dp_a, aa);
        chk("load_noack", {ack1, ack0}, 0);
        for (int k = 0; k < N; k++) begin
            step();
            chk("bit_ld", acc_ld, bb[k]);
            chk("bit_srsel", srsel, (k == N - 1) ? 0 : 2);
            chk("bit_clr", acc_clr, 0);
            chk("bit_noack", {ack1, ack0}, 0);
            chk("bit_nodone", {done1, done0}, 0);
        end
        step();
        chk("cap_ctl", {acc_ld, acc_clr, srsel}, 0);
        chk("cap_busy", busy, 1);
        chk("cap_nodone", {done1, done0}, 0);
        step();
        chk("done", {done1, done0}, who ? 2'b10 : 2'b01);
        chk("product", product, exp_p);
        chk("done_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        step();
        step();
        chk("rst_ack", {ack1, ack0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ctl", {acc_ld, acc_clr, srsel}, 0);
        chk("rst_product", product, 0);
        chk("rst_dpa", dp_a, 0);
        rst = 1'b0;
        step();

        // 1: single job, 3*5
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        #1;
        chk("t1_ack", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'd3, 4'd5, 8'd15, 1'b0, 1'b0, 4'd3, 4'd5);
        step();
        chk("t1_done_pulse", {done1, done0}, 0);
        chk("t1_hold", product, 15);

        // 2: simultaneous requests after reset, back-to-back
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
        req1 = 1'b1; a1 = 4'd7; b1 = 4'd9;
        #1;
        chk("t2_ack0", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'd2, 4'd3, 8'd6, 1'b0, 1'b1, 4'd2, 4'd3);
        chk("t2_ack1_b2b", {ack1, ack0}, 2'b10);
        run_job(1'b1, 4'd7, 4'd9, 8'd63, 1'b0, 1'b0, 4'd7, 4'd9);

        // 3: req1 held while busy, then round-robin over four jobs
        step();
        req0 = 1'b1; a0 = 4'd1; b0 = 4'd2;
        a1 = 4'd3; b1 = 4'd4;
        #1;
        chk("t3_ack0", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'd1, 4'd2, 8'd2, 1'b1, 1'b1, 4'd1, 4'd2);
        chk("t3_ack1", {ack1, ack0}, 2'b10);
        run_job(1'b1, 4'd3, 4'd4, 8'd12, 1'b1, 1'b1, 4'd3, 4'd4);
        chk("t3_ack0b", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'd1, 4'd2, 8'd2, 1'b0, 1'b1, 4'd1, 4'd2);
        chk("t3_ack1b", {ack1, ack0}, 2'b10);
        run_job(1'b1, 4'd3, 4'd4, 8'd12, 1'b0, 1'b0, 4'd3, 4'd4);

        // 4: b=0, then maximum operands
        step();
        req0 = 1'b1; a0 = 4'hF; b0 = 4'h0;
        #1;
        chk("t4_ack0", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'hF, 4'h0, 8'd0, 1'b1, 1'b0, 4'hF, 4'hF);
        chk("t4_ack0_max", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'hF, 4'hF, 8'd225, 1'b0, 1'b0, 4'hF, 4'hF);

        // 5: reset in bit step k=2 aborts the job
        step();
        req1 = 1'b1; a1 = 4'd5; b1 = 4'd6;
        #1;
        chk("t5_ack1", {ack1, ack0}, 2'b10);
        step();
        req1 = 1'b0;
        step();
        step();
        step();
        chk("t5_bit2_ld", acc_ld, 1);
        chk("t5_bit2_srsel", srsel, 2);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ctl", {acc_ld, acc_clr, srsel}, 0);
        chk("t5_rst_dpa", dp_a, 0);
        chk("t5_rst_product", product, 0);
        chk("t5_rst_done", {done1, done0}, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_no_done", {done1, done0}, 0);
            chk("t5_idle", busy, 0);
        end
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
        #1;
        chk("t5_ack0", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'd6, 4'd7, 8'd42, 1'b0, 1'b0, 4'd6, 4'd7);

        // 6: operands changed and req dropped right after ack
        step();
        req0 = 1'b1; a0 = 4'd9; b0 = 4'hB;
        #1;
        chk("t6_ack0", {ack1, ack0}, 2'b01);
        run_job(1'b0, 4'd9, 4'hB, 8'd99, 1'b0, 1'b0, 4'd2, 4'd1);
        step();
        chk("t6_no_ack", {ack1, ack0}, 0);
        chk("t6_hold", product, 99);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
